// File: rtl/demux1x4_buf_pkg.sv
// Shared constants for the 1:4 stream demux: lane select codes and per-lane counter width.
// Optional per-lane load counters are enabled with DEMUX_CNT_EN.
`ifndef DEMUX1X4_BUF_PKG_SV
`define DEMUX1X4_BUF_PKG_SV

package demux1x4_buf_pkg;

  localparam logic [1:0] LANE0 = 2'b00;
  localparam logic [1:0] LANE1 = 2'b01;
  localparam logic [1:0] LANE2 = 2'b10;
  localparam logic [1:0] LANE3 = 2'b11;

  localparam int CNT_W = 8;

endpackage

`endif

// File: rtl/demux1x4_buf_lane.sv
// demux_lane: one-entry output buffer. Output appears 1 cycle after load; a full lane reloads only on the cycle it drains.
// With DEMUX_CNT_EN defined, an 8-bit wrapping load counter is added.
module demux_lane
  import demux1x4_buf_pkg::*;
#(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  logic valid_nxt;

  // The parent only loads an empty or draining lane, so load always wins.
  always_comb begin
    valid_nxt = valid;
    if (load) begin
      valid_nxt = 1'b1;
    end else if (valid && ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else begin
      valid <= valid_nxt;
    end
  end

  // Payload is held until the next load, keeping it stable while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux1x4_buf.sv
// 1:4 valid/ready demux with a one-entry buffer per lane; 1-cycle accept-to-valid latency.
// in_ready follows only the selected lane, so a stalled lane never blocks the others. DEMUX_CNT_EN adds lane_cnt.
module demux1x4_buf
  import demux1x4_buf_pkg::*;
#(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out0_data,
  output logic [width-1:0] out1_data,
  output logic [width-1:0] out2_data,
  output logic [width-1:0] out3_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]      lane_cnt
`endif
);

  logic             accept;
  logic [3:0]       load;
  logic [width-1:0] lane_data [4];

  assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      case (in_sel)
        LANE0:   load[0] = 1'b1;
        LANE1:   load[1] = 1'b1;
        LANE2:   load[2] = 1'b1;
        LANE3:   load[3] = 1'b1;
        default: load    = 4'b0000;
      endcase
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt [4];
  assign lane_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

  for (genvar i = 0; i < 4; i++) begin : g_lane
    demux_lane #(
      .width(width)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[i]),
      .load_data(in_data),
      .ready    (out_ready[i]),
      .valid    (out_valid[i]),
      .data     (lane_data[i])
`ifdef DEMUX_CNT_EN
      ,
      .cnt      (cnt[i])
`endif
    );
  end

  assign out0_data = lane_data[0];
  assign out1_data = lane_data[1];
  assign out2_data = lane_data[2];
  assign out3_data = lane_data[3];

endmodule

// File: tb/tb_demux1x4_buf.sv
// Bench for demux1x4_buf at width 8: directed scenarios plus randomized traffic against a queue-per-lane model.
// Counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_demux1x4_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out0_data, out1_data, out2_data, out3_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
`ifdef DEMUX_CNT_EN
  logic [31:0] lane_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model: each lane is a queue of capacity one; counters are plain byte tallies.
  logic [7:0] lane_q [4][$];
  logic [7:0] mcnt [4];
  logic [7:0] od [4];

  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign od[3] = out3_data;

  always #5 clk = ~clk;

  demux1x4_buf #(.width(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out0_data(out0_data),
    .out1_data(out1_data),
    .out2_data(out2_data),
    .out3_data(out3_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DEMUX_CNT_EN
    ,
    .lane_cnt (lane_cnt)
`endif
  );

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (lane_q[i].size() != 0);
    return v;
  endfunction

  function automatic logic exp_ready();
    return (lane_q[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      lane_q[i].delete();
      mcnt[i] = 8'd0;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // One clock edge; model moves with it (pop before push since capacity is one).
  task automatic tick();
    logic       acc;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] r;
    acc = in_valid && exp_ready();
    s = in_sel;
    d = in_data;
    r = out_ready;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 4; i++)
        if (lane_q[i].size() != 0 && r[i]) void'(lane_q[i].pop_front());
      if (acc) begin
        lane_q[s].push_back(d);
        mcnt[s] = mcnt[s] + 8'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'b10, 8'h5A, 4'b0000);
    tick();
    tick();
    model_clear();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valid got %b want 0000", out_valid);
    end
    checks++;
    if ({out0_data, out1_data, out2_data, out3_data} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {out0_data, out1_data, out2_data, out3_data});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
`ifdef DEMUX_CNT_EN
    checks++;
    if (lane_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h want 0", lane_cnt);
    end
`endif
    rst_n = 1'b1;
    #1;
    tick();
    checks++;
    if (out_valid !== 4'b0100 || out2_data !== 8'h5A) begin
      errors++;
      $display("FAIL reset_first_load got valid=%b d2=%h want 0100/5a", out_valid, out2_data);
    end
  endtask

  task automatic test_fill();
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    drive(1'b0, 2'b00, 8'h00, 4'b1111);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), pat[i], 4'b0000);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready lane=%0d got %b want 1", i, in_ready);
      end
      tick();
    end
    drive(1'b0, 2'b00, 8'h00, 4'b0000);
    checks++;
    if (out_valid !== 4'b1111) begin
      errors++;
      $display("FAIL fill_valid got %b want 1111", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od[i] !== pat[i]) begin
        errors++;
        $display("FAIL fill_data lane=%0d got %h want %h", i, od[i], pat[i]);
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b0, 2'b00, 8'h00, 4'b1000);
    tick();
    drive(1'b1, 2'b01, 8'h99, 4'b0000);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid[1] !== 1'b1 || out1_data !== 8'h22) begin
      errors++;
      $display("FAIL stall_hold got v=%b d=%h want 1/22", out_valid[1], out1_data);
    end
    drive(1'b1, 2'b11, 8'h77, 4'b0000);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_other_ready got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b1111 || out3_data !== 8'h77 || out1_data !== 8'h22) begin
      errors++;
      $display("FAIL stall_other_load got v=%b d3=%h d1=%h want 1111/77/22", out_valid, out3_data, out1_data);
    end
  endtask

  task automatic test_throughput();
    int loads = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2'b00, 8'hAA + 8'(k), 4'b0001);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL thru_ready cyc=%0d got %b want 1", k, in_ready);
      end else begin
        loads++;
      end
      tick();
      checks++;
      if (out_valid[0] !== 1'b1 || out0_data !== 8'hAA + 8'(k)) begin
        errors++;
        $display("FAIL thru_data cyc=%0d got v=%b d=%h want 1/%h", k, out_valid[0], out0_data, 8'hAA + 8'(k));
      end
    end
    checks++;
    if (loads != 10) begin
      errors++;
      $display("FAIL thru_count got %0d want 10", loads);
    end
  endtask

  task automatic test_drain();
    drive(1'b0, 2'b00, 8'h00, 4'b1111);
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL drain_valid got %b want 0000", out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        // Asynchronous reset with lanes likely full; inputs offered during reset must be ignored.
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (out_valid !== 4'b0000) begin
          errors++;
          $display("FAIL rand_async_reset got %b want 0000", out_valid);
        end
        drive(1'b1, 2'($urandom_range(3)), 8'($urandom), 4'b0000);
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin
          errors++;
          $display("FAIL rand_reset_noload got %b want 0000", out_valid);
        end
      end
      drive(1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom), 4'($urandom));
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready cyc=%0d got %b want %b", c, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== exp_valid()) begin
        errors++;
        $display("FAIL rand_valid cyc=%0d got %b want %b", c, out_valid, exp_valid());
      end
      for (int i = 0; i < 4; i++) begin
        if (lane_q[i].size() != 0) begin
          checks++;
          if (od[i] !== lane_q[i][0]) begin
            errors++;
            $display("FAIL rand_data cyc=%0d lane=%0d got %h want %h", c, i, od[i], lane_q[i][0]);
          end
        end
      end
`ifdef DEMUX_CNT_EN
      checks++;
      if (lane_cnt !== {mcnt[3], mcnt[2], mcnt[1], mcnt[0]}) begin
        errors++;
        $display("FAIL rand_cnt cyc=%0d got %h want %h", c, lane_cnt, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
      end
`endif
    end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter();
    rst_n = 1'b0;
    #1;
    model_clear();
    drive(1'b0, 2'b00, 8'h00, 4'b0000);
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 257; k++) begin
      drive(1'b1, 2'b10, 8'(k), 4'b0100);
      tick();
    end
    checks++;
    if (lane_cnt !== 32'h0001_0000) begin
      errors++;
      $display("FAIL cnt_wrap got %h want 00010000", lane_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_stall();
    test_throughput();
    test_drain();
    test_random();
`ifdef DEMUX_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
